ysyx_22041207_ifu_axi_bridge: RTL
=================================

YSYX_22041207_IFU_AXI_BRIDGE -- requirements
Module: ysyx_22041207_ifu_axi_bridge

Interface
REQ-001 Parameter: AXI_ID, 4'd0, constant ARID value driven on every fetch.
REQ-002 Parameter: DW, 64, read data width; fixed at 64 for this core.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_r_valid_i  input  1  fetch address valid from IF.
REQ-006 rx_r_ready_o  output  1  bridge accepts a fetch address this cycle.
REQ-007 rx_r_addr_i  input  64  fetch byte address (pc).
REQ-008 rx_r_size_i  input  8  byte-lane mask of the request; legal values 8'h0F and 8'hFF.
REQ-009 rx_data_read_o  output  64  aligned doubleword holding the fetched instruction.
REQ-010 rx_data_valid  output  1  rx_data_read_o valid.
REQ-011 rx_data_ready  input  1  IF consumes read data.
REQ-012 rx_err  output  1  response error qualifier, valid with rx_data_valid.
REQ-013 arid/araddr/arlen/arsize/arburst  output  4/64/8/3/2  AXI4 AR payload.
REQ-014 arvalid  output  1; arready  input  1  AR handshake.
REQ-015 rid/rdata/rresp/rlast  input  4/64/2/1  AXI4 R payload.
REQ-016 rvalid  input  1; rready  output  1  R handshake.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, DATA, RESP; one fetch outstanding at a time.
REQ-018 rx_r_ready_o SHALL be 1 exactly when state==IDLE (combinational from state).
REQ-019 IDLE: on rx_r_valid_i&&rx_r_ready_o, latch araddr={rx_r_addr_i[63:3],3'b000}, latch size-error = (rx_r_size_i not 8'h0F/8'hFF); next state ADDR.
REQ-020 AR payload SHALL be constant per fetch: arid=AXI_ID, arlen=0, arsize=3'b011, arburst=2'b01.
REQ-021 ADDR: arvalid=1, araddr stable until arready sampled high; then DATA next cycle.
REQ-022 DATA: rready=1; on rvalid capture rdata into rx_data_read_o; next state RESP.
REQ-023 Captured error = size-error OR rresp[1] OR !rlast OR rid!=AXI_ID; registered into rx_err on R handshake.
REQ-024 RESP: rx_data_valid=1; rx_data_read_o and rx_err held stable until rx_data_ready; on rx_data_valid&&rx_data_ready next state IDLE.
REQ-025 Minimum latency: request accept to rx_data_valid = 3 cycles with arready and rvalid high on first cycle offered.
REQ-026 Back-to-back: after RESP handshake, IDLE SHALL accept a new request the following cycle; no idle bubble beyond that.
REQ-027 arvalid SHALL never deassert before arready; rready SHALL be 0 outside DATA.
REQ-028 rvalid outside DATA SHALL be ignored (no capture, no state change).
REQ-029 rx_r_addr_i[2] is not used by the bridge; IF selects the 32-bit half.
REQ-030 rx_data_ready while not in RESP SHALL have no effect.

Reset
REQ-031 On rst (any state, including mid ADDR/DATA): state<=IDLE, arvalid=0, rready=0, rx_data_valid=0, rx_err=0, araddr=0, rx_data_read_o=0.
REQ-032 A fetch interrupted by rst SHALL be abandoned; no data for it SHALL ever reach IF.
REQ-033 rx_r_ready_o SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Basic: addr 64'h8000_0004, size 8'h0F, arready/rvalid immediate, rdata 64'h00100093_00000413 -> araddr 64'h8000_0000, arsize 3, rx_data_valid 3 cycles later, data matches, rx_err 0.
REQ-035 Backpressure: arready delayed 5 cycles, rvalid delayed 7 -> arvalid/araddr stable throughout, single R capture, data correct.
REQ-036 IF stall: rx_data_ready low 4 cycles in RESP -> rx_data_read_o, rx_err, rx_data_valid held; rx_r_ready_o stays 0.
REQ-037 Errors: rresp=2'b10 -> rx_err 1; size 8'h03 with OKAY -> rx_err 1; rlast 0 -> rx_err 1.
REQ-038 Reset mid-fetch: rst asserted in DATA before rvalid, then stale rvalid -> no rx_data_valid, next request from 64'h8000_0008 returns correct data.
REQ-039 Streaming: 16 sequential fetches from 64'h8000_0000 step 4, always-ready slave -> each data returned in order, one accept per 4 cycles.

Source files
------------

// File: rtl/ysyx_22041207_ifu_axi_bridge.sv
// ysyx_22041207_ifu_axi_bridge
// Instruction-fetch to AXI4 read bridge. It accepts one fetch request at a
// time from the IF stage and issues a single-beat 64-bit AXI4 read for the
// doubleword that holds the instruction. It returns the whole aligned
// doubleword, and IF selects the 32-bit half it needs.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   rx_r_valid_i/ready_o : fetch request handshake (ready only while idle)
//   rx_r_addr_i          : fetch byte address (pc)
//   rx_r_size_i          : byte-lane mask; 8'h0F and 8'hFF are legal
//   rx_data_read_o       : fetched aligned doubleword
//   rx_data_valid/ready  : response handshake towards IF
//   rx_err               : response error, qualified by rx_data_valid
//   ar*                  : AXI4 read-address channel (master side)
//   r*                   : AXI4 read-data channel (master side)
module ysyx_22041207_ifu_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'd0,
   parameter int          DW     = 64
) (
   input  logic          clk,
   input  logic          rst,
   // IF request side
   input  logic          rx_r_valid_i,
   output logic          rx_r_ready_o,
   input  logic [63:0]   rx_r_addr_i,
   input  logic [7:0]    rx_r_size_i,
   // IF response side
   output logic [DW-1:0] rx_data_read_o,
   output logic          rx_data_valid,
   input  logic          rx_data_ready,
   output logic          rx_err,
   // AXI4 read-address channel
   output logic [3:0]    arid,
   output logic [63:0]   araddr,
   output logic [7:0]    arlen,
   output logic [2:0]    arsize,
   output logic [1:0]    arburst,
   output logic          arvalid,
   input  logic          arready,
   // AXI4 read-data channel
   input  logic [3:0]    rid,
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    rresp,
   input  logic          rlast,
   input  logic          rvalid,
   output logic          rready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [63:0]     araddr_reg;
   logic            size_err_reg;
   logic [DW-1:0]   data_reg;
   logic            err_reg;

   // Only SLVERR/DECERR matter (rresp[1]); the low address bits are dropped
   // because every fetch reads a full aligned doubleword.
   logic            unused_bits;
   assign unused_bits = ^{rx_r_addr_i[2:0], rresp[0]};

   // Next-state logic and handshake outputs. All handshake outputs are
   // decoded from the state alone, so they never glitch with inputs.
   always_comb begin
      state_next    = state_reg;
      rx_r_ready_o  = 1'b0;
      arvalid       = 1'b0;
      rready        = 1'b0;
      rx_data_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            rx_r_ready_o = 1'b1;
            if (rx_r_valid_i) begin
               state_next = ADDR;
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (arready) begin
               state_next = DATA;
            end
         end
         DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               state_next = RESP;
            end
         end
         RESP: begin
            rx_data_valid = 1'b1;
            if (rx_data_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         araddr_reg   <= 64'd0;
         size_err_reg <= 1'b0;
         data_reg     <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         // Address and size check are frozen at accept time so the AR
         // payload stays stable for as long as the slave stalls.
         if (state_reg == IDLE && rx_r_valid_i) begin
            araddr_reg   <= {rx_r_addr_i[63:3], 3'b000};
            size_err_reg <= (rx_r_size_i != 8'h0F) && (rx_r_size_i != 8'hFF);
         end
         // Single capture point: data/error change only on the R handshake,
         // which keeps them stable through any IF stall in RESP.
         if (state_reg == DATA && rvalid) begin
            data_reg <= rdata;
            err_reg  <= size_err_reg | rresp[1] | ~rlast | (rid != AXI_ID);
         end
      end
   end

   assign araddr         = araddr_reg;
   assign arid           = AXI_ID;
   assign arlen          = 8'd0;
   assign arsize         = 3'b011;
   assign arburst        = 2'b01;
   assign rx_data_read_o = data_reg;
   assign rx_err         = err_reg;

endmodule
